aes_cipher_iter: RTL

- Iterative AES encryption core. Consumes the full expanded key schedule `w` produced by `keyexpansion` and encrypts one 128-bit block.
- Executes one round per clock and sits directly downstream of `keyexpansion`.
- Valid/ready handshakes on input and output; one block in flight at a time.
- Supports AES-128/192/256 through `Nr`.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_cipher_iter_if.sv | 27 ++
 rtl/aes_round.sv | 27 ++
 rtl/aes_cipher_iter.sv | 87 ++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box table, GF(2^8) column mixing, ShiftRows and FSM encoding.
package aes_pkg;

    localparam int unsigned AES_BLK = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Forward S-box, entry b at bits 8b..8b+7
    localparam logic [0:2047] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TAB[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes a0..a3 are most-significant first
    function automatic logic [31:0] mixcolumn(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte k = 4*col + row; row r rotates left by r columns
    function automatic logic [0:AES_BLK-1] shiftrows(input logic [0:AES_BLK-1] s);
        logic [0:AES_BLK-1] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Block handshake and key-schedule bundle between key expansion, the cipher core and its consumer.
interface aes_cipher_iter_if #(
    parameter int unsigned NR = 10
);
    import aes_pkg::*;

    localparam int unsigned NW = 4*NR + 4;

    logic [0:32*NW-1]   w;
    logic               in_valid;
    logic               in_ready;
    logic [0:AES_BLK-1] in_block;
    logic               out_valid;
    logic               out_ready;
    logic [0:AES_BLK-1] out_block;

    modport master (
        output w, in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  w, in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns unless last, then AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [0:AES_BLK-1] state,
    input  logic [0:AES_BLK-1] rkey,
    input  logic               last,
    output logic [0:AES_BLK-1] nxt
);

    logic [0:AES_BLK-1] sb;
    logic [0:AES_BLK-1] sr;
    logic [0:AES_BLK-1] mc;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign sb[8*i +: 8] = sbox(state[8*i +: 8]);
    end

    assign sr = shiftrows(sb);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[32*c +: 32] = mixcolumn(sr[32*c +: 32]);
    end

    assign nxt = (last ? sr : mc) ^ rkey;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock over an externally held key schedule.
// AES_DONE_ACCEPT_EN lets a new block enter straight from DONE during the output handshake.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    aes_cipher_iter_if.slave bus
);

    state_t             fsm;
    state_t             fsm_nxt;
    logic [0:AES_BLK-1] state;
    logic [0:AES_BLK-1] rnd_out;
    logic [0:AES_BLK-1] out_block_q;
    logic               out_valid_q;
    logic [3:0]         rnd;
    logic               in_rdy;
    logic               accept;
    logic               last;

    aes_round u_round (
        .state (state),
        .rkey  (bus.w[{rnd, 7'b0} +: AES_BLK]),
        .last  (last),
        .nxt   (rnd_out)
    );

    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (accept) fsm_nxt = ROUND;
            ROUND:   if (last) fsm_nxt = DONE;
            DONE:    if (bus.out_ready) fsm_nxt = accept ? ROUND : IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy = 1'b0;
        last   = (rnd == 4'(Nr));
        case (fsm)
            IDLE:    in_rdy = !rst;
`ifdef AES_DONE_ACCEPT_EN
            DONE:    in_rdy = !rst && bus.out_ready;
`endif
            default: in_rdy = 1'b0;
        endcase
        accept = bus.in_valid && in_rdy;
    end

    // Final round writes straight to the output register so state is free for the next load
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= '0;
            rnd         <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                state <= bus.in_block ^ bus.w[0 +: AES_BLK];
                rnd   <= 4'd1;
            end else if (fsm == ROUND) begin
                if (last) begin
                    out_block_q <= rnd_out;
                    out_valid_q <= 1'b1;
                end else begin
                    state <= rnd_out;
                    rnd   <= rnd + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;

endmodule
